// File: rtl/gray_sched_pkg.sv
// Shared types and helpers for the Gray-coded interval timer scheduler.
// Build option: define GRAY_SCHED_ABORT_EN so that an owner dropping its request mid-run
// releases the counter early without a done pulse.
package gray_sched_pkg;

  // Defaults for the shared-counter configuration
  localparam int unsigned DefW    = 5;
  localparam int unsigned DefNreq = 4;
  localparam int unsigned DefIdxW = $clog2(DefNreq);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StRel
  } state_e;

  // Binary to reflected Gray code; callers cast the result down to their width
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/gray_rr_arbiter.sv
// Combinational round-robin picker: scans from rr_ptr_i+1 upwards (mod NREQ) and
// returns the first asserted request as a one-hot vector and as an index.
module gray_rr_arbiter
  import gray_sched_pkg::*;
#(
  parameter int unsigned NREQ = DefNreq,
  parameter int unsigned IdxW = DefIdxW
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IdxW-1:0] rr_ptr_i,
  output logic [NREQ-1:0] pick_o,
  output logic [IdxW-1:0] idx_o
);

  logic            found;
  int unsigned     k;
  logic [IdxW-1:0] kk;

  // Rotated priority scan; the last slot checked is rr_ptr_i itself
  always_comb begin
    pick_o = '0;
    idx_o  = '0;
    found  = 1'b0;
    k      = 0;
    kk     = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      k  = (32'(rr_ptr_i) + off) % NREQ;
      kk = IdxW'(k);
      if (!found && req_i[kk]) begin
        found      = 1'b1;
        pick_o[kk] = 1'b1;
        idx_o      = kk;
      end
    end
  end

endmodule

// File: rtl/gray_timer_sched.sv
// One Gray-coded interval counter shared among NREQ requesters by round-robin.
// IDLE arbitrates, RUN counts 0..len_lat, REL drops the grant and shows the done pulse.
// Build option: GRAY_SCHED_ABORT_EN lets the owner abort a run by dropping its request.
module gray_timer_sched
  import gray_sched_pkg::*;
#(
  parameter int unsigned W    = DefW,
  parameter int unsigned NREQ = DefNreq
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ*W-1:0] len,
  output logic [NREQ-1:0] grant,
  output logic            busy,
  output logic [NREQ-1:0] done,
  output logic [W-1:0]    gray_q
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [W-1:0]    bin_q, bin_d;
  logic [W-1:0]    len_lat_q, len_lat_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;

  logic [NREQ-1:0] pick;
  logic [IdxW-1:0] pick_idx;
  logic [W-1:0]    len_sel;
  logic            abort;

  gray_rr_arbiter #(
    .NREQ (NREQ),
    .IdxW (IdxW)
  ) u_arb (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .pick_o   (pick),
    .idx_o    (pick_idx)
  );

  // Length slice of the requester about to be granted
  always_comb begin
    len_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) len_sel = len[i*W +: W];
    end
  end

`ifdef GRAY_SCHED_ABORT_EN
  // Owner withdrew its request while running
  assign abort = ~|(req & grant_q);
`else
  assign abort = 1'b0;
`endif

  // Next-state logic: arbitration, counting, release
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    done_d    = '0;
    bin_d     = bin_q;
    len_lat_d = len_lat_q;
    rr_ptr_d  = rr_ptr_q;
    unique case (state_q)
      StIdle: begin
        bin_d = '0;
        if (|req) begin
          state_d   = StRun;
          grant_d   = pick;
          len_lat_d = len_sel;
          rr_ptr_d  = pick_idx;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StRel;
          grant_d = '0;
          bin_d   = '0;
        end else if (bin_q == len_lat_q) begin
          // Terminal count: pulse done to the owner while the grant drops
          state_d = StRel;
          done_d  = grant_q;
          grant_d = '0;
          bin_d   = '0;
        end else begin
          bin_d = bin_q + 1'b1;
        end
      end
      StRel: begin
        state_d = StIdle;
        grant_d = '0;
        bin_d   = '0;
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
        bin_d   = '0;
      end
    endcase
  end

  // State and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      done_q    <= '0;
      bin_q     <= '0;
      len_lat_q <= '0;
      rr_ptr_q  <= IdxW'(NREQ - 1);
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      bin_q     <= bin_d;
      len_lat_q <= len_lat_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign grant  = grant_q;
  assign done   = done_q;
  assign busy   = (state_q == StRun);
  // bin_q is zero outside RUN, so the Gray output is zero when idle
  assign gray_q = W'(bin2gray(32'(bin_q)));

endmodule

// File: tb/tb_gray_timer_sched.sv
// Directed bench for gray_timer_sched (W=5, NREQ=4): a cycle table for reset, single
// request and round-robin, plus hand sequences for full-length, abort and mid-run reset.
module tb_gray_timer_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [19:0] len;
  logic [3:0]  grant;
  logic        busy;
  logic [3:0]  done;
  logic [4:0]  gray_q;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gray_timer_sched #(
    .W    (5),
    .NREQ (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .len    (len),
    .grant  (grant),
    .busy   (busy),
    .done   (done),
    .gray_q (gray_q)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [19:0] len;
    logic [3:0]  grant;
    logic        busy;
    logic [3:0]  done;
    logic [4:0]  gray;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] rq, input logic [19:0] ln,
                     input logic [3:0] g, input logic b, input logic [3:0] d,
                     input logic [4:0] gr);
    vec_t v;
    v.rst = r; v.req = rq; v.len = ln; v.grant = g; v.busy = b; v.done = d; v.gray = gr;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h want %0h", name, idx, act, exp);
    end
  endtask

  // Apply current inputs across one rising edge; outputs are read 1 ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int idx, input logic [3:0] g,
                           input logic b, input logic [3:0] d, input logic [4:0] gr);
    check({tag, ".grant"}, idx, 32'(grant), 32'(g));
    check({tag, ".busy"},  idx, 32'(busy),  32'(b));
    check({tag, ".done"},  idx, 32'(done),  32'(d));
    check({tag, ".gray"},  idx, 32'(gray_q), 32'(gr));
  endtask

  function automatic logic [4:0] g5(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [4:0] prev_gray;

  initial begin
    rst = 1'b1;
    req = '0;
    len = '0;

    // Reset held two cycles with all requests high
    add(1, 4'b1111, 20'h0, 4'b0000, 0, 4'b0000, 5'd0);
    add(1, 4'b1111, 20'h0, 4'b0000, 0, 4'b0000, 5'd0);
    // Single request, len[2]=3: Gray 0,1,3,2 then done in REL
    add(0, 4'b0000, 20'h00C00, 4'b0000, 0, 4'b0000, 5'd0);
    add(0, 4'b0100, 20'h00C00, 4'b0100, 1, 4'b0000, 5'd0);
    add(0, 4'b0100, 20'h00C00, 4'b0100, 1, 4'b0000, 5'd1);
    add(0, 4'b0100, 20'h00C00, 4'b0100, 1, 4'b0000, 5'd3);
    add(0, 4'b0100, 20'h00C00, 4'b0100, 1, 4'b0000, 5'd2);
    add(0, 4'b0100, 20'h00C00, 4'b0000, 0, 4'b0100, 5'd0);
    add(0, 4'b0000, 20'h00C00, 4'b0000, 0, 4'b0000, 5'd0);
    // Re-reset, then all four requesting with len 0
    add(1, 4'b0000, 20'h0, 4'b0000, 0, 4'b0000, 5'd0);
    for (int i = 0; i < 5; i++) begin
      logic [3:0] oh;
      oh = 4'b0001 << (i % 4);
      add(0, 4'b1111, 20'h0, oh,      1, 4'b0000, 5'd0);
      add(0, 4'b1111, 20'h0, 4'b0000, 0, oh,      5'd0);
      add(0, (i == 4) ? 4'b0000 : 4'b1111, 20'h0, 4'b0000, 0, 4'b0000, 5'd0);
    end

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      req = vecs[i].req;
      len = vecs[i].len;
      tick();
      check_all("tbl", i, vecs[i].grant, vecs[i].busy, vecs[i].done, vecs[i].gray);
    end

    // Full-length interval: len[0]=31 gives 32 RUN cycles, no wrap, single-bit steps
    rst = 1'b1; req = '0; len = '0;
    tick();
    rst = 1'b0; req = 4'b0001; len = 20'h0001F;
    tick();
    check_all("max", 0, 4'b0001, 1, 4'b0000, 5'd0);
    prev_gray = gray_q;
    for (int c = 1; c < 32; c++) begin
      tick();
      check("max.busy", c, 32'(busy), 32'd1);
      check("max.gray", c, 32'(gray_q), 32'(g5(5'(c))));
      check("max.step", c, 32'($countones(gray_q ^ prev_gray)), 32'd1);
      prev_gray = gray_q;
    end
    check("max.last", 31, 32'(gray_q), 32'b10000);
    req = 4'b0000;
    tick();
    check_all("max.rel", 32, 4'b0000, 0, 4'b0001, 5'd0);

    // Owner drops request at count 2 of len 7
    rst = 1'b1; tick();
    rst = 1'b0; req = 4'b0001; len = 20'h00007;
    tick(); tick(); tick();
    check("abt.cnt2", 0, 32'(gray_q), 32'(g5(5'd2)));
    req = 4'b0000;
    tick();
`ifdef GRAY_SCHED_ABORT_EN
    check_all("abt.rel", 1, 4'b0000, 0, 4'b0000, 5'd0);
    tick();
    check_all("abt.idle", 2, 4'b0000, 0, 4'b0000, 5'd0);
`else
    check_all("abt.run", 1, 4'b0001, 1, 4'b0000, g5(5'd3));
    for (int c = 4; c <= 7; c++) tick();
    check_all("abt.end", 2, 4'b0001, 1, 4'b0000, g5(5'd7));
    tick();
    check_all("abt.done", 3, 4'b0000, 0, 4'b0001, 5'd0);
`endif

    // Reset at count 4 of len 10 for requester 1, then requester 0 wins first
    rst = 1'b1; req = '0; tick();
    rst = 1'b0; req = 4'b0010; len = 20'h00140;
    tick();
    for (int c = 1; c <= 4; c++) tick();
    check_all("rst.cnt4", 0, 4'b0010, 1, 4'b0000, g5(5'd4));
    rst = 1'b1;
    tick();
    check_all("rst.hit", 1, 4'b0000, 0, 4'b0000, 5'd0);
    rst = 1'b0; req = 4'b1111; len = 20'h0;
    tick();
    check_all("rst.first", 2, 4'b0001, 1, 4'b0000, 5'd0);
    tick();
    check_all("rst.done", 3, 4'b0000, 0, 4'b0001, 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
